// File: rtl/i2c_arbiter.sv
// Two-requester arbiter in front of a shared I2C master: round-robin grant,
// latched transaction fields, two-cycle start strobe and per-phase timeout.
module i2c_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req,
  input  logic [13:0] dev_addr_in,
  input  logic [15:0] reg_addr_in,
  input  logic [15:0] data_in,
  input  logic [1:0]  wr_rd_in,
  output logic [1:0]  grant,
  output logic [1:0]  done,
  output logic [1:0]  err,
  input  logic        i2c_busy,
  output logic        i2c_start,
  output logic [6:0]  i2c_addr,
  output logic [7:0]  i2c_reg,
  output logic [7:0]  i2c_data,
  output logic        i2c_wr_rd
);

  localparam int unsigned CW = ($clog2(TIMEOUT_CYC) > 10) ? $clog2(TIMEOUT_CYC) : 10;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, START1, START2, WAIT_BUSY, WAIT_DONE, RELEASE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_q;
  logic          win;

  // Contention goes to whoever was not served last; otherwise the sole requester.
  always_comb begin
    win = (req == 2'b11) ? ~last_q : req[1];
  end

  // err doubles as the timeout flag: it is only ever loaded alongside done
  // on entry to RELEASE and cleared the cycle after.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last_q    <= 1'b1;
      grant     <= '0;
      done      <= '0;
      err       <= '0;
      i2c_start <= 1'b0;
      i2c_addr  <= '0;
      i2c_reg   <= '0;
      i2c_data  <= '0;
      i2c_wr_rd <= 1'b0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        IDLE: begin
          if (!i2c_busy && (req != '0)) begin
            state     <= START1;
            grant     <= win ? 2'b10 : 2'b01;
            last_q    <= win;
            i2c_start <= 1'b1;
            i2c_addr  <= win ? dev_addr_in[13:7] : dev_addr_in[6:0];
            i2c_reg   <= win ? reg_addr_in[15:8] : reg_addr_in[7:0];
            i2c_data  <= win ? data_in[15:8]     : data_in[7:0];
            i2c_wr_rd <= win ? wr_rd_in[1]       : wr_rd_in[0];
          end
        end
        START1: state <= START2;
        START2: begin
          state     <= WAIT_BUSY;
          i2c_start <= 1'b0;
          cnt       <= '0;
        end
        WAIT_BUSY: begin
          if (i2c_busy) begin
            state <= WAIT_DONE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= RELEASE;
            cnt   <= '0;
            done  <= grant;
            err   <= grant;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_DONE: begin
          if (!i2c_busy) begin
            state <= RELEASE;
            cnt   <= '0;
            done  <= grant;
          end else if (cnt == CNT_LAST) begin
            state <= RELEASE;
            cnt   <= '0;
            done  <= grant;
            err   <= grant;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RELEASE: begin
          state <= IDLE;
          grant <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Scoreboard bench for i2c_arbiter: transaction-level predictions are queued at
// issue time and checked by an independent monitor; a responder models the master.
module tb_i2c_arbiter;
  localparam int unsigned T = 24;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req = '0;
  logic [13:0] dev_addr_in = '0;
  logic [15:0] reg_addr_in = '0;
  logic [15:0] data_in = '0;
  logic [1:0]  wr_rd_in = '0;
  logic [1:0]  grant, done, err;
  logic        i2c_busy, i2c_start, i2c_wr_rd;
  logic [6:0]  i2c_addr;
  logic [7:0]  i2c_reg, i2c_data;
  logic        mbusy = 1'b0;
  logic        idle_busy = 1'b0;

  assign i2c_busy = mbusy | idle_busy;

  i2c_arbiter #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .dev_addr_in(dev_addr_in),
    .reg_addr_in(reg_addr_in), .data_in(data_in), .wr_rd_in(wr_rd_in),
    .grant(grant), .done(done), .err(err), .i2c_busy(i2c_busy),
    .i2c_start(i2c_start), .i2c_addr(i2c_addr), .i2c_reg(i2c_reg),
    .i2c_data(i2c_data), .i2c_wr_rd(i2c_wr_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] g;
    logic [6:0] a;
    logic [7:0] r;
    logic [7:0] d;
    logic       w;
    logic       e;
    int         k;
  } exp_t;

  typedef struct {
    int d;
    int h;
    bit never;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    errors = 0;
  int    checks = 0;
  int    last_srv = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Master responder: busy high for cycles [d, d+h) counted from the grant cycle.
  plan_t mp;
  int    mk = 0;
  bit    mactive = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      mactive = 0;
      mbusy   = 1'b0;
    end else if (!mactive) begin
      if (grant != '0 && plan_q.size() > 0) begin
        mp      = plan_q.pop_front();
        mactive = 1;
        mk      = 0;
        mbusy   = 1'b0;
      end
    end else if (done != '0) begin
      mactive = 0;
      mbusy   = 1'b0;
    end else begin
      mk++;
      mbusy = !mp.never && (mk >= mp.d) && (mk < mp.d + mp.h);
    end
  end

  // Monitor
  exp_t ce;
  bit   active = 0;
  int   mon_k = 0;
  int   starts = 0;
  int   cyc = 0;
  int   last_done = -100;
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      active    = 0;
      last_done = -100;
    end else begin
      chk("onehot_owner", {31'b0, $onehot0(grant) && ((done & ~grant) == '0) && ((err & ~done) == '0)}, 32'd1);
      if (!active) begin
        if (grant != '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_grant", {30'b0, grant}, 32'd0);
          end else begin
            ce     = exp_q.pop_front();
            active = 1;
            mon_k  = 0;
            starts = i2c_start ? 1 : 0;
            chk("grant", {30'b0, grant}, {30'b0, ce.g});
            chk("i2c_addr", {25'b0, i2c_addr}, {25'b0, ce.a});
            chk("i2c_reg", {24'b0, i2c_reg}, {24'b0, ce.r});
            chk("i2c_data", {24'b0, i2c_data}, {24'b0, ce.d});
            chk("i2c_wr_rd", {31'b0, i2c_wr_rd}, {31'b0, ce.w});
            chk("grant_gap", {31'b0, (cyc - last_done) >= 2}, 32'd1);
          end
        end
      end else begin
        mon_k++;
        if (i2c_start) starts++;
        if (done != '0) begin
          chk("done_owner", {30'b0, done}, {30'b0, ce.g});
          chk("err", {30'b0, err}, {30'b0, ce.e ? ce.g : 2'b00});
          chk("done_cycle", mon_k, ce.k);
          chk("start_len", starts, 32'd2);
          chk("data_hold", {24'b0, i2c_data}, {24'b0, ce.d});
          chk("addr_hold", {25'b0, i2c_addr}, {25'b0, ce.a});
          active    = 0;
          last_done = cyc;
        end else if (mon_k > int'(T) + 40) begin
          chk("done_timeout", mon_k, ce.k);
          active = 0;
        end
      end
    end
  end

  task automatic run_txn(input logic [1:0] r, input logic [13:0] a, input logic [15:0] rg,
                         input logic [15:0] dt, input logic [1:0] wr, input int d, input int h,
                         input bit never, input bit scr, input int hold);
    exp_t  e;
    plan_t p;
    int    w;
    int    n;
    w = (r == 2'b11) ? 1 - last_srv : ((r == 2'b10) ? 1 : 0);
    last_srv = w;
    e.g = (w == 1) ? 2'b10 : 2'b01;
    e.a = (w == 1) ? a[13:7] : a[6:0];
    e.r = (w == 1) ? rg[15:8] : rg[7:0];
    e.d = (w == 1) ? dt[15:8] : dt[7:0];
    e.w = (w == 1) ? wr[1] : wr[0];
    e.e = never || (h > int'(T));
    e.k = never ? int'(T) + 2 : d + 1 + ((h < int'(T)) ? h : int'(T));
    p.d = d;
    p.h = h;
    p.never = never;
    exp_q.push_back(e);
    plan_q.push_back(p);
    req = r; dev_addr_in = a; reg_addr_in = rg; data_in = dt; wr_rd_in = wr;
    if (hold > 0) begin
      idle_busy = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        chk("busy_holdoff", {30'b0, grant}, 32'd0);
      end
      idle_busy = 1'b0;
      @(negedge clk);
      chk("grant_after_busy", {30'b0, grant}, {30'b0, e.g});
    end else begin
      @(negedge clk);
    end
    n = 0;
    while (grant == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (grant == '0) begin
      chk("grant_wait", {30'b0, grant}, {30'b0, e.g});
      exp_q.delete(); plan_q.delete(); req = '0;
      return;
    end
    if (scr) begin
      repeat ($urandom_range(1, d + 1)) @(negedge clk);
      req = 2'($urandom); dev_addr_in = 14'($urandom); reg_addr_in = 16'($urandom);
      data_in = 16'($urandom); wr_rd_in = 2'($urandom);
    end
    n = 0;
    while (done == '0 && n < int'(T) + 50) begin
      @(negedge clk);
      n++;
    end
    if (done == '0) begin
      chk("done_wait", {30'b0, done}, {30'b0, e.g});
      exp_q.delete(); plan_q.delete();
    end
    req = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_state", {1'b0, grant, done, err, i2c_start, i2c_addr, i2c_reg, i2c_data, i2c_wr_rd}, 32'd0);
    reset_n = 1'b1;

    // Contention from reset: 01, 10, 01
    repeat (3) run_txn(2'b11, 14'($urandom), 16'($urandom), 16'($urandom), 2'($urandom), 2, 4, 0, 0, 0);
    run_txn(2'b01, {7'h55, 7'h1A}, {8'hAA, 8'h0C}, 16'hFF00, 2'b10, 3, 20, 0, 0, 0);
    run_txn(2'b01, 14'h1234, 16'h5678, 16'h9ABC, 2'b01, 2, 0, 1, 0, 0);
    run_txn(2'b10, 14'h2ABC, 16'h1357, 16'h2468, 2'b10, 4, int'(T), 0, 0, 0);
    run_txn(2'b01, 14'h0F0F, 16'h3C3C, 16'h5A5A, 2'b00, 5, int'(T) + 1, 0, 0, 0);
    run_txn(2'b01, 14'h0123, 16'h4567, 16'h89A5, 2'b00, 2, 12, 0, 1, 0);
    run_txn(2'b01, 14'h0077, 16'h0066, 16'h0055, 2'b01, 3, 5, 0, 0, 3);

    // Reset during WAIT_DONE, then requester 1 alone
    exp_q.push_back('{g:2'b01, a:7'h11, r:8'h22, d:8'h33, w:1'b0, e:1'b0, k:0});
    plan_q.push_back('{d:2, h:30, never:0});
    req = 2'b01; dev_addr_in = 14'h0011; reg_addr_in = 16'h0022; data_in = 16'h0033; wr_rd_in = 2'b00;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant == '0 && n < 20);
    req = '0;
    repeat (6) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("async_reset", {1'b0, grant, done, err, i2c_start, i2c_addr, i2c_reg, i2c_data, i2c_wr_rd}, 32'd0);
    exp_q.delete(); plan_q.delete();
    last_srv = 1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_txn(2'b10, 14'h3F80, 16'hBB00, 16'hCC00, 2'b10, 2, 6, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      run_txn(2'($urandom_range(1, 3)), 14'($urandom), 16'($urandom), 16'($urandom), 2'($urandom),
              $urandom_range(2, 6), $urandom_range(1, T + 6), ($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : 0);
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1023, sets the cycles allowed per busy phase before abort.
REQ-002 clk  input  1  single system clock, all logic on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 req  input  2  per-requester transaction request level; bit i = requester i.
REQ-005 dev_addr_in  input  14  7-bit device address per requester, {req1,req0}.
REQ-006 reg_addr_in  input  16  8-bit register address per requester, {req1,req0}.
REQ-007 data_in  input  16  8-bit write data per requester, {req1,req0}.
REQ-008 wr_rd_in  input  2  per-requester direction, 0 = write.
REQ-009 grant  output  2  one-hot owner of the I2C master, 00 when idle.
REQ-010 done  output  2  one-cycle completion pulse to the owner.
REQ-011 err  output  2  one-cycle timeout pulse to the owner, coincident with done.
REQ-012 i2c_busy  input  1  busy level from the shared I2C master.
REQ-013 i2c_start  output  1  start strobe to the I2C master.
REQ-014 i2c_addr / i2c_reg / i2c_data / i2c_wr_rd  output  7/8/8/1  latched transaction fields to the I2C master.

Function
REQ-015 FSM states SHALL be IDLE, START1, START2, WAIT_BUSY, WAIT_DONE, RELEASE.
REQ-016 IDLE: req is sampled only here; with i2c_busy=0 and any req bit set, the arbiter SHALL grant and go to START1 next cycle; otherwise stay.
REQ-017 Single request: that requester wins.
REQ-018 Both requesting: the requester not served last (last_q) wins; last_q resets to 1 so requester 0 wins first contention.
REQ-019 On grant the winner's dev_addr, reg_addr, data, wr_rd SHALL be latched into registers driving i2c_* outputs; later input changes SHALL not affect the transaction.
REQ-020 grant SHALL assert from START1 through RELEASE inclusive; last_q updates to the winner at grant.
REQ-021 i2c_start SHALL be 1 in START1 and START2 only (exact two-cycle pulse); START1->START2->WAIT_BUSY unconditionally.
REQ-022 WAIT_BUSY: i2c_busy=1 -> WAIT_DONE; else count; counter reaching TIMEOUT_CYC-1 -> RELEASE with timeout flag set.
REQ-023 WAIT_DONE: i2c_busy=0 -> RELEASE; else count (counter cleared on entry); reaching TIMEOUT_CYC-1 -> RELEASE with timeout flag set.
REQ-024 Timeout counter SHALL be 10 bits wide minimum, clear on every state entry, saturate never (exit precedes wrap).
REQ-025 RELEASE lasts one cycle: done[owner]=1; err[owner]=1 only if timeout flag set; then IDLE with grant=00 and timeout flag cleared.
REQ-026 Requester deasserting req after grant SHALL NOT abort; the transaction completes normally.
REQ-027 A requester holding req through done SHALL be eligible again in the following IDLE cycle (minimum two-cycle gap between grants).
REQ-028 i2c_busy=1 in IDLE with pending req SHALL hold off grant until i2c_busy=0.
REQ-029 done and err SHALL never assert for a non-owner; at most one bit of grant/done/err is set.

Reset
REQ-030 reset_n=0 at any time, including mid-transaction, SHALL force IDLE immediately: grant=00, done=00, err=00, i2c_start=0, i2c_addr/reg/data=0, i2c_wr_rd=0, counter=0, last_q=1, timeout flag=0.
REQ-031 After reset release, arbitration SHALL resume on the first rising edge with reset_n=1.

Verification
REQ-032 req=01, addr0=0x1A, reg0=0x0C, data0=0x00; master raises busy 3 cycles after start, holds 20 cycles -> grant=01, i2c_start high exactly 2 cycles, i2c_addr=0x1A, i2c_reg=0x0C, one done[0] pulse, err=00.
REQ-033 req=11 held through three transactions from reset -> grants in order 01, 10, 01, each separated by ≥2 cycles.
REQ-034 Master never raises busy after start -> after TIMEOUT_CYC cycles in WAIT_BUSY done[owner]=1 and err[owner]=1 same cycle, then grant=00.
REQ-035 Change data_in and drop req during WAIT_DONE -> i2c_data keeps latched value, done still pulses.
REQ-036 Assert reset_n=0 during WAIT_DONE -> all outputs zero asynchronously; after release, req=10 alone is granted normally.
REQ-037 i2c_busy=1 in IDLE with req=01 -> no grant until busy drops, grant on the next edge.
